// File: rtl/cfg_reg_arbiter.sv
// Configuration register file with round-robin SPI/local write arbitration.
// Local requester also gets read-back; out-of-range accesses are flagged.
module cfg_reg_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_req,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_data,
  output logic              spi_ack,
  output logic              spi_err,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic              loc_ack,
  output logic              loc_err,
  output logic [DATA_W-1:0] loc_rdata,
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [7:0]        pwm_duty_cycle,
  output logic              busy
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W:0] NREG = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              last_loc;
  logic              grant;
  logic              pick_loc;
  logic              g_loc;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic [IDX_W-1:0]  g_idx;
  logic              in_range;
  logic [DATA_W-1:0] regs [NUM_REGS];

  // Full-width compare: high address bits never alias onto real registers.
  assign in_range = ({1'b0, g_addr} < NREG);
  assign g_idx    = g_addr[IDX_W-1:0];

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    pick_loc = 1'b0;
    unique case (state)
      IDLE: begin
        if (spi_req || loc_req) begin
          grant    = 1'b1;
          pick_loc = loc_req && (!spi_req || !last_loc);
          state_nx = EXEC;
        end
      end
      EXEC:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_loc  <= 1'b1;
      g_loc     <= 1'b0;
      g_we      <= 1'b0;
      g_addr    <= '0;
      g_data    <= '0;
      loc_rdata <= '0;
      spi_ack   <= 1'b0;
      spi_err   <= 1'b0;
      loc_ack   <= 1'b0;
      loc_err   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      state   <= state_nx;
      spi_ack <= 1'b0;
      spi_err <= 1'b0;
      loc_ack <= 1'b0;
      loc_err <= 1'b0;
      if (grant) begin
        last_loc <= pick_loc;
        g_loc    <= pick_loc;
        g_addr   <= pick_loc ? loc_addr : spi_addr;
        g_data   <= pick_loc ? loc_wdata : spi_data;
        g_we     <= pick_loc ? loc_we : 1'b1;
      end
      if (state == EXEC) begin
        if (in_range && g_we) begin
          regs[g_idx] <= g_data;
        end
        if (!g_we) begin
          loc_rdata <= in_range ? regs[g_idx] : '0;
        end
        if (g_loc) begin
          loc_ack <= 1'b1;
          loc_err <= !in_range;
        end else begin
          spi_ack <= 1'b1;
          spi_err <= !in_range;
        end
      end
    end
  end

  assign en_reg_out_7_0  = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0  = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle  = regs[4];
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Directed bench for cfg_reg_arbiter: timing, arbitration, errors, reset.
// Inputs are driven 1 time unit after each rising edge and sampled there.
module tb_cfg_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_req;
  logic [6:0] spi_addr;
  logic [7:0] spi_data;
  logic       spi_ack;
  logic       spi_err;
  logic       loc_req;
  logic       loc_we;
  logic [6:0] loc_addr;
  logic [7:0] loc_wdata;
  logic       loc_ack;
  logic       loc_err;
  logic [7:0] loc_rdata;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  cfg_reg_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spi_req         (spi_req),
    .spi_addr        (spi_addr),
    .spi_data        (spi_data),
    .spi_ack         (spi_ack),
    .spi_err         (spi_err),
    .loc_req         (loc_req),
    .loc_we          (loc_we),
    .loc_addr        (loc_addr),
    .loc_wdata       (loc_wdata),
    .loc_ack         (loc_ack),
    .loc_err         (loc_err),
    .loc_rdata       (loc_rdata),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] regs_all();
    return {r0, r1, r2, r3, r4};
  endfunction

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d,
                           input logic exp_err);
    spi_addr = a;
    spi_data = d;
    spi_req  = 1'b1;
    tick;
    chk("spi_c1_ack", spi_ack, 0);
    chk("spi_c1_busy", busy, 1);
    tick;
    chk("spi_c2_ack", spi_ack, 1);
    chk("spi_c2_err", spi_err, exp_err);
    chk("spi_c2_locack", loc_ack, 0);
    spi_req = 1'b0;
    tick;
    chk("spi_c3_ack", spi_ack, 0);
    chk("spi_c3_busy", busy, 0);
  endtask

  task automatic loc_access(input logic we, input logic [6:0] a,
                            input logic [7:0] d, input logic exp_err,
                            input logic [7:0] exp_rd);
    loc_we    = we;
    loc_addr  = a;
    loc_wdata = d;
    loc_req   = 1'b1;
    tick;
    chk("loc_c1_ack", loc_ack, 0);
    tick;
    chk("loc_c2_ack", loc_ack, 1);
    chk("loc_c2_err", loc_err, exp_err);
    chk("loc_c2_spiack", spi_ack, 0);
    if (!we) chk("loc_c2_rdata", loc_rdata, exp_rd);
    loc_req = 1'b0;
    tick;
    chk("loc_c3_ack", loc_ack, 0);
    chk("loc_c3_busy", busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    spi_req   = 1'b0;
    spi_addr  = '0;
    spi_data  = '0;
    loc_req   = 1'b0;
    loc_we    = 1'b0;
    loc_addr  = '0;
    loc_wdata = '0;
    tick;
    tick;
    chk("rst_regs", regs_all(), 40'h0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {spi_ack, spi_err, loc_ack, loc_err}, 4'b0);
    chk("rst_rdata", loc_rdata, 8'h00);
    rst_n = 1'b1;
    tick;

    // SPI write 0x04 <- 0x80 with cycle-exact timing
    spi_addr = 7'h04;
    spi_data = 8'h80;
    spi_req  = 1'b1;
    chk("t1_c0_busy", busy, 0);
    tick;
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_ack", spi_ack, 0);
    chk("t1_c1_pwm", r4, 8'h00);
    tick;
    chk("t1_c2_ack", spi_ack, 1);
    chk("t1_c2_err", spi_err, 0);
    chk("t1_c2_busy", busy, 1);
    chk("t1_c2_pwm", r4, 8'h80);
    spi_req = 1'b0;
    tick;
    chk("t1_c3_ack", spi_ack, 0);
    chk("t1_c3_busy", busy, 0);

    spi_write(7'h02, 8'hA5, 1'b0);
    loc_access(1'b0, 7'h02, 8'h00, 1'b0, 8'hA5);
    chk("t3_regs", regs_all(), 40'h00_00_A5_00_80);

    // Collision, last grant LOC: SPI first
    spi_addr  = 7'h00;
    spi_data  = 8'hFF;
    spi_req   = 1'b1;
    loc_we    = 1'b1;
    loc_addr  = 7'h00;
    loc_wdata = 8'h0F;
    loc_req   = 1'b1;
    tick;
    chk("t4_c1_busy", busy, 1);
    tick;
    chk("t4_c2_spiack", spi_ack, 1);
    chk("t4_c2_locack", loc_ack, 0);
    chk("t4_c2_r0", r0, 8'hFF);
    spi_req = 1'b0;
    tick;
    chk("t4_c3_acks", {spi_ack, loc_ack}, 2'b00);
    tick;
    chk("t4_c4_r0", r0, 8'hFF);
    tick;
    chk("t4_c5_locack", loc_ack, 1);
    chk("t4_c5_spiack", spi_ack, 0);
    chk("t4_c5_err", loc_err, 0);
    chk("t4_c5_r0", r0, 8'h0F);
    loc_req = 1'b0;
    tick;
    chk("t4_c6_locack", loc_ack, 0);
    chk("t4_rdata_hold", loc_rdata, 8'hA5);

    spi_write(7'h05, 8'h33, 1'b1);
    chk("t5_regs", regs_all(), 40'h0F_00_A5_00_80);

    // Collision again, last grant SPI: LOC first
    spi_addr  = 7'h01;
    spi_data  = 8'hAA;
    spi_req   = 1'b1;
    loc_we    = 1'b1;
    loc_addr  = 7'h01;
    loc_wdata = 8'hBB;
    loc_req   = 1'b1;
    tick;
    tick;
    chk("t5b_c2_locack", loc_ack, 1);
    chk("t5b_c2_spiack", spi_ack, 0);
    chk("t5b_c2_r1", r1, 8'hBB);
    loc_req = 1'b0;
    tick;
    tick;
    tick;
    chk("t5b_c5_spiack", spi_ack, 1);
    chk("t5b_c5_locack", loc_ack, 0);
    chk("t5b_c5_r1", r1, 8'hAA);
    spi_req = 1'b0;
    tick;

    loc_access(1'b0, 7'h7F, 8'h00, 1'b1, 8'h00);
    chk("t6_regs", regs_all(), 40'h0F_AA_A5_00_80);

    // Reset while the write is in EXEC
    spi_addr = 7'h01;
    spi_data = 8'h55;
    spi_req  = 1'b1;
    tick;
    chk("t7_exec_busy", busy, 1);
    rst_n   = 1'b0;
    spi_req = 1'b0;
    tick;
    chk("t7_ack", spi_ack, 0);
    chk("t7_r1", r1, 8'h00);
    chk("t7_busy", busy, 0);
    chk("t7_regs", regs_all(), 40'h0);
    rst_n = 1'b1;
    tick;
    chk("t7_idle_ack", spi_ack, 0);
    spi_write(7'h01, 8'h55, 1'b0);
    chk("t7_after", regs_all(), 40'h00_55_00_00_00);

    // LOC held high, SPI back-to-back; last grant SPI so LOC leads
    loc_we    = 1'b1;
    loc_addr  = 7'h03;
    loc_wdata = 8'h3C;
    loc_req   = 1'b1;
    spi_addr  = 7'h04;
    spi_data  = 8'h99;
    spi_req   = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick;
      chk($sformatf("t8_locack_c%0d", c), loc_ack, (c % 6) == 2);
      chk($sformatf("t8_spiack_c%0d", c), spi_ack, (c % 6) == 5);
      if (spi_ack) spi_req = 1'b0;
      else spi_req = 1'b1;
    end
    spi_req = 1'b0;
    loc_req = 1'b0;
    tick;
    tick;
    chk("t8_busy", busy, 0);
    chk("t8_regs", regs_all(), 40'h00_55_00_3C_99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cfg_reg_arbiter.md
Name: cfg_reg_arbiter

Overview:
Owns the five PWM/output configuration registers and shares write access between two requesters: the SPI peripheral's commit port and a local on-chip requester (sequencer/self-test). Arbitration is round-robin with a level-request / one-cycle-ack handshake. It also decodes addresses, flags out-of-range accesses, and gives the local requester read-back. Sits between the SPI front end and the output-enable/PWM datapath, which consumes the register outputs directly.

Parameters:
ADDR_W, 7, request address width
DATA_W, 8, register/data width
NUM_REGS, 5, implemented registers at addresses 0..NUM_REGS-1

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-low
spi_req  input  1  SPI write request; level, held until spi_ack
spi_addr  input  ADDR_W  SPI target address; stable while spi_req high
spi_data  input  DATA_W  SPI write data; stable while spi_req high
spi_ack  output  1  one-cycle completion pulse to SPI
spi_err  output  1  valid with spi_ack; out-of-range address
loc_req  input  1  local request; level, held until loc_ack
loc_we  input  1  1 = write, 0 = read
loc_addr  input  ADDR_W  local target address
loc_wdata  input  DATA_W  local write data
loc_ack  output  1  one-cycle completion pulse to local
loc_err  output  1  valid with loc_ack; out-of-range address
loc_rdata  output  DATA_W  read data; valid with loc_ack on a read
en_reg_out_7_0  output  8  register 0x00
en_reg_out_15_8  output  8  register 0x01
en_reg_pwm_7_0  output  8  register 0x02
en_reg_pwm_15_8  output  8  register 0x03
pwm_duty_cycle  output  8  register 0x04
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: rst_n is sampled on the rising edge of clk. All five registers, loc_rdata, both acks, both errs, and busy are cleared to 0. FSM goes to IDLE and last_grant = LOC, so SPI wins the first tie.
- Reset mid-operation drops the in-flight access: no register update and no ack.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - Only spi_req high: grant SPI.
  - Only loc_req high: grant LOC.
  - Both high: grant the requester that is not last_grant.
  - On grant: latch requester ID, address, data and we (SPI always we=1). Update last_grant, then go to EXEC.
- EXEC (one cycle):
  - If latched addr < NUM_REGS: a write updates the register at the clock edge ending EXEC; a read captures the register into loc_rdata at the same edge.
  - Otherwise: no register change, the granted requester's err is set, and loc_rdata is forced to 0 on a read.
  - The granted requester's ack is set at that edge. Go to DONE.
- DONE (one cycle): ack (and err, if set) is high for exactly this cycle, then go to IDLE unconditionally.
  - The requester must deassert req at the edge ending its ack cycle.
  - A req still high in IDLE is treated as a new request.
- Latency: req high in cycle 0 (IDLE) gives register update at the end of cycle 1 and ack in cycle 2. Peak throughput is one access per 3 cycles.
- Requests arriving while busy wait. No request is lost while req is held.
- Ack and err are registered outputs. The non-granted requester's ack/err stay 0.
- loc_rdata holds its value until the next local read completes.
- Address compare uses the full ADDR_W bits (e.g. 0x84 >> 7-bit 0x04 is impossible; 0x7F is out of range). No aliasing on low bits.
- Registers change only in EXEC. Outputs are stable in all other cycles.

Test Plan:
- Reset then SPI write addr 0x04 data 0x80 -> pwm_duty_cycle = 0x80 from cycle 2; spi_ack high only in cycle 2; spi_err = 0; busy high in cycles 1-2.
- spi_req and loc_req rise in the same cycle, SPI addr 0x00 data 0xFF, LOC write addr 0x00 data 0x0F -> SPI served first (ack cycle 2), LOC second (ack cycle 5); final en_reg_out_7_0 = 0x0F. Repeat the collision -> LOC served first.
- LOC read addr 0x02 after SPI wrote 0xA5 -> loc_ack with loc_rdata = 0xA5, loc_err = 0; no register changes.
- SPI write addr 0x05 data 0x33, then LOC read addr 0x7F -> spi_ack with spi_err = 1 and all registers unchanged; loc_ack with loc_err = 1 and loc_rdata = 0x00.
- Assert rst_n low during EXEC of a write 0x01 <- 0x55 -> no ack; en_reg_out_15_8 = 0x00 after reset; FSM in IDLE; next request completes normally.
- Hold loc_req high continuously while SPI issues back-to-back writes -> grants alternate SPI/LOC; each requester acked every 6 cycles; no starvation.
